// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single shared memory port of the multicycle MIPS core (CPU + aux port).
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN; the default is fixed CPU priority.
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ack,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_AUX  = 2'b10;
   localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [3:0]          cnt_r;
   logic [1:0]          grant_r;
   logic [1:0]          win_s;
   logic [1:0]          tie_s;
   logic                mem_en_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic                cpu_ack_r;
   logic                aux_ack_r;
   logic [DATA_W-1:0]   cpu_rdata_r;
   logic [DATA_W-1:0]   aux_rdata_r;

`ifdef MEM_ARB_RR_EN
   logic [1:0] last_grant_r;

   // Remember the most recent winner so that ties alternate between requesters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= GNT_AUX;
      end else if ((state_r == ST_IDLE) && (win_s != GNT_NONE)) begin
         last_grant_r <= win_s;
      end
   end

   assign tie_s = (last_grant_r == GNT_AUX) ? GNT_CPU : GNT_AUX;
`else
   assign tie_s = GNT_CPU;
`endif

   // Pick the requester to serve if the port were free this cycle.
   always_comb begin
      win_s = GNT_NONE;
      if (cpu_req && aux_req) begin
         win_s = tie_s;
      end else if (cpu_req) begin
         win_s = GNT_CPU;
      end else if (aux_req) begin
         win_s = GNT_AUX;
      end else begin
         win_s = GNT_NONE;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state; RESP always returns to IDLE so every access sees at least one idle cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (win_s != GNT_NONE) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (WAIT_LD == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Command latch, wait counter, acknowledge pulses and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= 4'd0;
         grant_r     <= GNT_NONE;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         cpu_ack_r   <= 1'b0;
         aux_ack_r   <= 1'b0;
         cpu_rdata_r <= {DATA_W{1'b0}};
         aux_rdata_r <= {DATA_W{1'b0}};
      end else begin
         mem_en_r  <= 1'b0;
         cpu_ack_r <= 1'b0;
         aux_ack_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (win_s != GNT_NONE) begin
                  grant_r  <= win_s;
                  mem_en_r <= 1'b1;
                  if (win_s == GNT_CPU) begin
                     mem_we_r    <= cpu_we;
                     mem_addr_r  <= cpu_addr;
                     mem_wdata_r <= cpu_wdata;
                  end else begin
                     mem_we_r    <= aux_we;
                     mem_addr_r  <= aux_addr;
                     mem_wdata_r <= aux_wdata;
                  end
               end
            end
            ST_ACCESS: cnt_r <= WAIT_LD;
            ST_WAIT:   cnt_r <= cnt_r - 4'd1;
            ST_RESP: begin
               grant_r  <= GNT_NONE;
               mem_we_r <= 1'b0;
               if (!mem_we_r) begin
                  if (grant_r == GNT_CPU) begin
                     cpu_rdata_r <= mem_rdata;
                  end else if (grant_r == GNT_AUX) begin
                     aux_rdata_r <= mem_rdata;
                  end
               end
            end
            default: grant_r <= GNT_NONE;
         endcase
         if (state_nxt_s == ST_RESP) begin
            cpu_ack_r <= (grant_r == GNT_CPU);
            aux_ack_r <= (grant_r == GNT_AUX);
         end
      end
   end

   // Memory data only settles during RESP, so the winner sees it directly in its ack cycle.
   assign cpu_rdata = ((state_r == ST_RESP) && (grant_r == GNT_CPU) && !mem_we_r) ? mem_rdata : cpu_rdata_r;
   assign aux_rdata = ((state_r == ST_RESP) && (grant_r == GNT_AUX) && !mem_we_r) ? mem_rdata : aux_rdata_r;

   assign cpu_ack   = cpu_ack_r;
   assign aux_ack   = aux_ack_r;
   assign cpu_stall = cpu_req & ~cpu_ack_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign grant     = grant_r;
   assign busy      = (state_r != ST_IDLE);

endmodule
